// File: rtl/prog_clk_divider.sv
// prog_clk_divider: runtime-programmable integer clock divider.
// Produces a registered divided clock with near-50% duty cycle plus
// single-cycle rise/fall strobes. New divisors arrive through a
// valid/ready handshake and are only applied at a period boundary.
module prog_clk_divider #(
  parameter int DIV_WIDTH = 16,
  parameter int RESET_DIV = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_div_valid,
  output logic                 o_div_ready,
  output logic [DIV_WIDTH-1:0] o_div_cur,
  output logic                 o_clk,
  output logic                 o_tick_rise,
  output logic                 o_tick_fall,
  output logic                 o_active
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Divisors of 0 or 1 cannot form a high and a low phase; store them as 2.
  localparam logic [DIV_WIDTH-1:0] RESET_DIV_RAW = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] RESET_DIV_CLAMPED =
    (RESET_DIV_RAW < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : RESET_DIV_RAW;

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_cur_q, div_cur_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  logic                 accept;
  logic                 period_end;
  // One bit wider than the divisor so ceil(D/2) cannot overflow at D = 2^W-1.
  logic [DIV_WIDTH:0]   high_len;
  logic [DIV_WIDTH:0]   cnt_ext;

  // Next-state logic: run/idle control, period counter and divisor handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    accept     = i_div_valid && !pend_vld_q;
    period_end = (state_q == ST_RUN) && (cnt_q == (div_cur_q - DIV_WIDTH'(1)));

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // In IDLE the divisor takes effect immediately, so a period started
        // on this same edge already uses it.
        if (accept) begin
          div_cur_d = clamp_div(i_div);
        end
        if (i_en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A transfer while running (even on the period-end edge) is parked
        // and applied at the following boundary.
        if (accept) begin
          pend_d     = clamp_div(i_div);
          pend_vld_d = 1'b1;
        end
        if (period_end) begin
          cnt_d = '0;
          if (pend_vld_q) begin
            div_cur_d  = pend_q;
            pend_vld_d = 1'b0;
          end
          if (!i_en) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so clock and strobes are registered together.
  always_comb begin
    high_len = ({1'b0, div_cur_d} + (DIV_WIDTH+1)'(1)) >> 1;
    cnt_ext  = {1'b0, cnt_d};
    clk_d    = 1'b0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (state_d == ST_RUN) begin
      clk_d  = (cnt_ext < high_len);
      rise_d = (cnt_d == '0);
      fall_d = (cnt_ext == high_len);
    end
  end

  // State and output registers; reset drops everything, including a pending divisor.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_cur_q  <= RESET_DIV_CLAMPED;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign o_div_ready = !pend_vld_q;
  assign o_div_cur   = div_cur_q;
  assign o_clk       = clk_q;
  assign o_tick_rise = rise_q;
  assign o_tick_fall = fall_q;
  assign o_active    = (state_q == ST_RUN);

endmodule

// File: tb/tb_prog_clk_divider.sv
// Testbench for prog_clk_divider: directed scenarios followed by random
// stimulus, every cycle compared against a period-position reference model.
module tb_prog_clk_divider;

  localparam int W = 8;

  logic         i_clk;
  logic         i_rst;
  logic         i_en;
  logic [W-1:0] i_div;
  logic         i_div_valid;
  logic         o_div_ready;
  logic [W-1:0] o_div_cur;
  logic         o_clk;
  logic         o_tick_rise;
  logic         o_tick_fall;
  logic         o_active;

  int vectors;
  int miscompares;

  // Reference model: position within the current period plus divisor bookkeeping.
  bit m_run;
  int m_pos;
  int m_div;
  int m_pend[$];

  prog_clk_divider #(
    .DIV_WIDTH(W),
    .RESET_DIV(2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_div       (i_div),
    .i_div_valid (i_div_valid),
    .o_div_ready (o_div_ready),
    .o_div_cur   (o_div_cur),
    .o_clk       (o_clk),
    .o_tick_rise (o_tick_rise),
    .o_tick_fall (o_tick_fall),
    .o_active    (o_active)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int clampf(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_div = 2;
    m_pend.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit accept;
    accept = i_div_valid && (m_pend.size() == 0);
    if (!m_run) begin
      if (accept) m_div = clampf(int'(i_div));
      if (i_en) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos == m_div - 1) begin
      if (m_pend.size() != 0) m_div = m_pend.pop_front();
      if (accept) m_pend.push_back(clampf(int'(i_div)));
      if (i_en) m_pos = 0;
      else begin
        m_run = 1'b0;
        m_pos = 0;
      end
    end else begin
      m_pos = m_pos + 1;
      if (accept) m_pend.push_back(clampf(int'(i_div)));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string where);
    int h;
    h = (m_div + 1) / 2;
    chk({where, ".active"}, 32'(o_active), 32'(m_run));
    chk({where, ".clk"}, 32'(o_clk), 32'(m_run && (m_pos < h)));
    chk({where, ".rise"}, 32'(o_tick_rise), 32'(m_run && (m_pos == 0)));
    chk({where, ".fall"}, 32'(o_tick_fall), 32'(m_run && (m_pos == h)));
    chk({where, ".ready"}, 32'(o_div_ready), 32'(m_pend.size() == 0));
    chk({where, ".div_cur"}, 32'(o_div_cur), 32'(m_div));
  endtask

  // One clock edge: update model, then compare outputs 1 time unit after the edge.
  task automatic step(input string where);
    model_edge();
    @(posedge i_clk);
    #1;
    check_all(where);
    $display("%s: en=%0b vld=%0b div=%0d -> clk=%0b rise=%0b fall=%0b act=%0b rdy=%0b cur=%0d",
             where, i_en, i_div_valid, i_div, o_clk, o_tick_rise, o_tick_fall,
             o_active, o_div_ready, o_div_cur);
  endtask

  task automatic run_steps(input string where, input int n);
    for (int k = 0; k < n; k++) step(where);
  endtask

  // Drop run request and let the current period finish (bounded).
  task automatic go_idle(input string where);
    bit done;
    done = 1'b0;
    i_en = 1'b0;
    i_div_valid = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!m_run && (m_pend.size() == 0)) begin
        done = 1'b1;
        break;
      end
      step(where);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $error("FAIL %s.idle_timeout: observed running expected idle", where);
    end
  endtask

  // Load a divisor while idle, in a single handshake cycle.
  task automatic load_idle(input string where, input int d);
    i_div = W'(d);
    i_div_valid = 1'b1;
    step(where);
    i_div_valid = 1'b0;
  endtask

  // Run until the model sits at the requested period position (bounded).
  task automatic run_to_pos(input string where, input int pos);
    for (int k = 0; k < 600; k++) begin
      if (m_run && m_pos == pos) break;
      step(where);
    end
  endtask

  task automatic async_reset(input string where);
    #2;
    i_rst = 1'b1;
    model_reset();
    #1;
    check_all({where, ".async"});
    @(posedge i_clk);
    #1;
    check_all({where, ".held"});
    i_rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_rst       = 1'b1;
    i_en        = 1'b0;
    i_div       = '0;
    i_div_valid = 1'b0;
    model_reset();

    // Reset values, both immediately and across an edge.
    #1;
    check_all("reset");
    @(posedge i_clk);
    #1;
    check_all("reset_hold");
    i_rst = 1'b0;
    run_steps("idle", 2);

    // Even ratio D=4.
    load_idle("even_load", 4);
    i_en = 1'b1;
    run_steps("even", 13);
    go_idle("even_stop");

    // Odd ratio D=5.
    load_idle("odd_load", 5);
    i_en = 1'b1;
    run_steps("odd", 16);
    go_idle("odd_stop");

    // Live change 4 -> 6, with an extra valid offered while not ready.
    load_idle("live_load", 4);
    i_en = 1'b1;
    run_steps("live_start", 4);
    run_to_pos("live_seek", 1);
    i_div = W'(6);
    i_div_valid = 1'b1;
    step("live_offer");
    i_div = W'(3);
    step("live_blocked");
    i_div_valid = 1'b0;
    run_steps("live_run", 16);
    go_idle("live_stop");

    // Disable mid-period with D=8, then restart.
    load_idle("dis_load", 8);
    i_en = 1'b1;
    run_to_pos("dis_seek", 1);
    i_en = 1'b0;
    run_steps("dis_drain", 10);
    i_en = 1'b1;
    run_steps("dis_restart", 3);
    go_idle("dis_stop");

    // Reset mid-run with D=6 and a pending divisor.
    load_idle("rst_load", 6);
    i_en = 1'b1;
    run_steps("rst_run", 2);
    i_div = W'(9);
    i_div_valid = 1'b1;
    step("rst_pend");
    i_div_valid = 1'b0;
    i_en = 1'b0;
    async_reset("rst_mid");
    run_steps("rst_idle", 3);

    // Clamp of 0 and 1.
    load_idle("clamp0", 0);
    load_idle("clamp1", 1);
    i_en = 1'b1;
    run_steps("clamp_run", 6);
    go_idle("clamp_stop");

    // Divisor load and start on the same edge.
    i_div = W'(3);
    i_div_valid = 1'b1;
    i_en = 1'b1;
    step("same_edge");
    i_div_valid = 1'b0;
    run_steps("same_edge_run", 6);
    go_idle("same_edge_stop");

    // Random stimulus.
    for (int k = 0; k < 500; k++) begin
      i_en = ($urandom_range(0, 9) != 0);
      i_div_valid = ($urandom_range(0, 3) == 0);
      i_div = W'($urandom_range(0, 9));
      step("rand");
    end
    go_idle("rand_stop");

    // Maximum divisor 2^W-1: one full period, then idle.
    load_idle("max_load", (1 << W) - 1);
    i_en = 1'b1;
    run_steps("max_start", 2);
    i_en = 1'b0;
    run_steps("max_run", 260);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_clk_divider.md
# prog_clk_divider

Runtime-programmable integer clock divider, successor to the fixed power-of-two divider. It generates a divided clock from `i_clk` for any integer ratio from 2 to 2^DIV_WIDTH−1, with near-50% duty cycle and single-cycle rise/fall strobes. A new ratio is taken through a valid/ready handshake and applied only at a period boundary, so the output never glitches. It sits in the misc/clocking area and feeds slow peripherals (UART/SPI/LED timing) either as a clock or, preferably, through the strobes as clock enables.

## Interface
- `DIV_WIDTH`, 16: width of the divisor and the internal counter.
- `RESET_DIV`, 2: divisor loaded at reset, clamped as described under Operation.
- `i_clk`  in  1  base clock, the only clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_en`  in  1  run request. Sampled every `i_clk` rising edge.
- `i_div`  in  DIV_WIDTH  requested divisor D.
- `i_div_valid`  in  1  `i_div` is valid.
- `o_div_ready`  out  1  block can accept a divisor.
- `o_div_cur`  out  DIV_WIDTH  divisor in effect, already clamped.
- `o_clk`  out  1  divided clock, registered.
- `o_tick_rise`  out  1  high for the first cycle of each high phase of `o_clk`.
- `o_tick_fall`  out  1  high for the first cycle of each low phase of `o_clk`.
- `o_active`  out  1  a period is in progress.

## Operation
- **Clamp.** Any accepted divisor, and `RESET_DIV`, with value 0 or 1 is stored as 2. No other value is altered.
- **Period.** With D = `o_div_cur`, one period is D cycles.
  - High phase H = ceil(D/2) cycles, then low phase L = floor(D/2) cycles.
  - An internal counter runs 0 … D−1. `o_clk` is 1 while count < H.
- **States.**
  - IDLE (`o_active`=0, `o_clk`=0).
  - RUN (`o_active`=1).
- **IDLE → RUN.** On the edge that samples `i_en`=1, the counter goes to 0. After that edge, `o_clk`=1, `o_tick_rise`=1 and `o_active`=1.
- **Period-end edge.** This is the edge in RUN where count = D−1.
  - If `i_en`=1, a new period starts (count 0, `o_tick_rise`=1).
  - If `i_en`=0, the block goes to IDLE.
  - Dropping `i_en` never truncates a period. The current period always completes, low phase included.
- **Divisor handshake.** Transfer occurs at an edge where `i_div_valid` and `o_div_ready` are both 1.
  - In IDLE: the value goes straight to `o_div_cur` at that edge and `o_div_ready` stays 1.
  - In RUN: the value goes to a pending register and `o_div_ready`=0 from the next cycle.
  - The pending value loads into `o_div_cur` at the next period-end edge, whether the block restarts or goes idle. `o_div_ready` returns to 1 after that edge.
  - A transfer on a period-end edge goes to pending. It takes effect at the following boundary, not the current one.
- **Blocking.** `i_div_valid` while `o_div_ready`=0 is ignored. The requester holds valid until it is accepted.
- **Ticks.** `o_tick_rise` and `o_tick_fall` are registered together with `o_clk` and are never both high in the same cycle.

## Timing
- **Reset values** (asynchronous, immediate):
  - `o_clk`=0, `o_tick_rise`=0, `o_tick_fall`=0, `o_active`=0.
  - `o_div_ready`=1, `o_div_cur`=clamp(`RESET_DIV`).
  - Counter 0, pending register empty.
- **Reset mid-period.** Outputs go to reset values without waiting for the period to end, and any pending divisor is discarded. Release is synchronous to the next `i_clk` edge. The first edge after release may already sample `i_en`.
- **Latency.** `i_en` rising → `o_clk` high: 1 edge. Divisor change in IDLE → used by the next period started: 0 extra cycles.
- **Steady state.** Rising-edge-to-rising-edge spacing of `o_clk` is exactly D cycles. The rise strobe has the same spacing.
- **Maximum divisor.** D = 2^DIV_WIDTH−1 must work. The counter never wraps inside a period.
- All outputs are flop-driven. There are no combinational paths from input to output.

## Test plan
- **Reset values.** Assert `i_rst` mid-run with D=6 → all outputs go to their reset values in the same cycle, `o_div_cur`=2 (`RESET_DIV`=2). After release, IDLE holds with `o_clk`=0.
- **Even ratio.** D=4, `i_en`=1 continuously → `o_clk`=1,1,0,0 repeating. `o_tick_rise` on cycles 0,4,8… and `o_tick_fall` on cycles 2,6,10….
- **Odd ratio.** D=5 → `o_clk`=1,1,1,0,0 repeating, `o_tick_fall` on the 4th cycle of each period.
- **Live change.** D=4 running, send D=6 at period cycle 1 → `o_div_ready`=0 until the period-end edge. The next period reads 1,1,1,0,0,0. A second valid offered while ready=0 is not accepted.
- **Disable mid-period.** Drop `i_en` at period cycle 1 with D=8 → full 4 high and 4 low cycles complete, then `o_active`=0 and `o_clk` stays 0. Re-assert `i_en` → `o_clk`=1 one edge later.
- **Clamp.** Load `i_div`=0, then `i_div`=1, in IDLE → `o_div_cur`=2 each time, and the run pattern is 1,0 repeating.
